// File: rtl/gf_inv_8_shared_pipe_pkg.sv
// Shared types, constants and GF((2^4)^2) normal-basis helpers for the masked byte inverter.
// Element layout: byte {hi, lo} is hi*Y^16 + lo*Y; nibbles and pairs follow the same high/low split.
package gf_inv_8_shared_pipe_pkg;

    localparam int unsigned SHARES       = 3;
    localparam int unsigned NIB_W        = 4;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned RND_PER_LANE = 16;

    typedef logic [NIB_W-1:0] nib_t;

    typedef struct packed {
        nib_t s1;
        nib_t s2;
        nib_t s3;
    } nib3_t;

    typedef struct packed {
        nib3_t hi;
        nib3_t lo;
        nib_t  sq_a;
        nib_t  sq_b;
        nib3_t mul;
        nib_t  r12;
    } stage1_t;

    typedef struct packed {
        nib3_t hi;
        nib3_t lo;
        nib3_t inv;
        nib_t  r34;
    } stage2_t;

    function automatic int unsigned latency(int unsigned out_reg);
        return 2 + out_reg;
    endfunction

    function automatic logic [1:0] gf_mul_2(logic [1:0] x, logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Scale by N = w^2 and by w in GF(2^2).
    function automatic logic [1:0] gf_scl_n_2(logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic logic [1:0] gf_scl_w_2(logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

    function automatic nib_t gf_muls_4(nib_t x, nib_t y);
        logic [1:0] e;
        e = gf_scl_n_2(gf_mul_2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf_mul_2(x[3:2], y[3:2]) ^ e, gf_mul_2(x[1:0], y[1:0]) ^ e};
    endfunction

    // nu * x^2 with nu = w*Z; squaring in GF(2^2) is a bit swap.
    function automatic nib_t gf_sq_scl_4(nib_t x);
        logic [1:0] ab;
        ab = x[3:2] ^ x[1:0];
        return {ab[0], ab[1], gf_scl_w_2({x[0], x[1]})};
    endfunction

    function automatic nib_t gf_inv_4(nib_t x);
        nib_t x2, x4, x8;
        x2 = gf_muls_4(x, x);
        x4 = gf_muls_4(x2, x2);
        x8 = gf_muls_4(x4, x4);
        return gf_muls_4(gf_muls_4(x2, x4), x8);
    endfunction

    // Three-share product: each output share omits one input share index.
    function automatic nib3_t gf_muls_4_shared(nib3_t a, nib3_t b);
        nib3_t q;
        q.s1 = gf_muls_4(a.s2, b.s2) ^ gf_muls_4(a.s2, b.s3) ^ gf_muls_4(a.s3, b.s2);
        q.s2 = gf_muls_4(a.s3, b.s3) ^ gf_muls_4(a.s1, b.s3) ^ gf_muls_4(a.s3, b.s1);
        q.s3 = gf_muls_4(a.s1, b.s1) ^ gf_muls_4(a.s1, b.s2) ^ gf_muls_4(a.s2, b.s1);
        return q;
    endfunction

    // x^-1 = x^14 = x^2 * x^4 * x^8; squaring is linear so it runs per share.
    function automatic nib3_t gf_inv_4_shared(nib3_t x);
        nib3_t x2, x4, x8;
        x2 = {gf_muls_4(x.s1, x.s1), gf_muls_4(x.s2, x.s2), gf_muls_4(x.s3, x.s3)};
        x4 = {gf_muls_4(x2.s1, x2.s1), gf_muls_4(x2.s2, x2.s2), gf_muls_4(x2.s3, x2.s3)};
        x8 = {gf_muls_4(x4.s1, x4.s1), gf_muls_4(x4.s2, x4.s2), gf_muls_4(x4.s3, x4.s3)};
        return gf_muls_4_shared(gf_muls_4_shared(x2, x4), x8);
    endfunction

    // Unmasked reference inversion.
    function automatic logic [7:0] gf_inv_8(logic [7:0] x);
        nib_t d;
        d = gf_inv_4(gf_sq_scl_4(x[7:4] ^ x[3:0]) ^ gf_muls_4(x[7:4], x[3:0]));
        return {gf_muls_4(d, x[3:0]), gf_muls_4(d, x[7:4])};
    endfunction

endpackage

// File: rtl/gf_inv_8_shared_lane.sv
// One byte lane of the masked inverter: two register stages, remasking with per-lane randomness.
module gf_inv_8_shared_lane
    import gf_inv_8_shared_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  sh1_in,
    input  logic [7:0]  sh2_in,
    input  logic [7:0]  sh3_in,
    input  logic [15:0] rnd,
    output logic [7:0]  sh1_out,
    output logic [7:0]  sh2_out,
    output logic [7:0]  sh3_out
);

    nib3_t   hi_in, lo_in, m, c, d, dd, oh, ol;
    stage1_t s1_d, s1_q;
    stage2_t s2_d, s2_q;

    // Stage 1: norm terms; share 3's square is folded into share 2.
    always_comb begin
        hi_in = {sh1_in[7:4], sh2_in[7:4], sh3_in[7:4]};
        lo_in = {sh1_in[3:0], sh2_in[3:0], sh3_in[3:0]};
        m     = gf_muls_4_shared(hi_in, lo_in);
        s1_d          = '0;
        s1_d.hi       = hi_in;
        s1_d.lo       = lo_in;
        s1_d.sq_a     = gf_sq_scl_4(hi_in.s1 ^ lo_in.s1);
        s1_d.sq_b     = gf_sq_scl_4(hi_in.s2 ^ lo_in.s2 ^ hi_in.s3 ^ lo_in.s3);
        s1_d.mul.s1   = m.s1;
        s1_d.mul.s2   = m.s2 ^ rnd[3:0];
        s1_d.mul.s3   = m.s3 ^ rnd[7:4];
        s1_d.r12      = rnd[3:0] ^ rnd[7:4];
    end

    // Stage 2: the r1^r2 compensation lands on share 1 before the nibble inversion.
    always_comb begin
        c = {s1_q.sq_a ^ s1_q.mul.s1 ^ s1_q.r12, s1_q.sq_b ^ s1_q.mul.s2, s1_q.mul.s3};
        d = gf_inv_4_shared(c);
        s2_d        = '0;
        s2_d.hi     = s1_q.hi;
        s2_d.lo     = s1_q.lo;
        s2_d.inv.s1 = d.s1;
        s2_d.inv.s2 = d.s2 ^ rnd[11:8];
        s2_d.inv.s3 = d.s3 ^ rnd[15:12];
        s2_d.r34    = rnd[11:8] ^ rnd[15:12];
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    always_comb begin
        dd = {s2_q.inv.s1 ^ s2_q.r34, s2_q.inv.s2, s2_q.inv.s3};
        oh = gf_muls_4_shared(dd, s2_q.lo);
        ol = gf_muls_4_shared(dd, s2_q.hi);
        sh1_out = {oh.s1, ol.s1};
        sh2_out = {oh.s2, ol.s2};
        sh3_out = {oh.s3, ol.s3};
    end

endmodule

// File: rtl/gf_inv_8_shared_pipe.sv
// Multi-lane three-share GF(2^8) inverter with valid tracking and optional output register.
module gf_inv_8_shared_pipe
    import gf_inv_8_shared_pipe_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned OUT_REG = 0
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [BYTE_W*LANES-1:0]      sh1_in,
    input  logic [BYTE_W*LANES-1:0]      sh2_in,
    input  logic [BYTE_W*LANES-1:0]      sh3_in,
    input  logic [RND_PER_LANE*LANES-1:0] rnd,
    output logic                         out_valid,
    output logic [BYTE_W*LANES-1:0]      sh1_out,
    output logic [BYTE_W*LANES-1:0]      sh2_out,
    output logic [BYTE_W*LANES-1:0]      sh3_out
);

    localparam int unsigned LAT = latency(OUT_REG);
    localparam int unsigned W   = BYTE_W * LANES;

    logic [LAT-1:0] valid_q;
    logic [W-1:0]   lane_sh1, lane_sh2, lane_sh3;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q <= {valid_q[LAT-2:0], in_valid};
        end
    end

    assign out_valid = valid_q[LAT-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf_inv_8_shared_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (clr),
            .sh1_in  (sh1_in[BYTE_W*k +: BYTE_W]),
            .sh2_in  (sh2_in[BYTE_W*k +: BYTE_W]),
            .sh3_in  (sh3_in[BYTE_W*k +: BYTE_W]),
            .rnd     (rnd[RND_PER_LANE*k +: RND_PER_LANE]),
            .sh1_out (lane_sh1[BYTE_W*k +: BYTE_W]),
            .sh2_out (lane_sh2[BYTE_W*k +: BYTE_W]),
            .sh3_out (lane_sh3[BYTE_W*k +: BYTE_W])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [W-1:0] o1_q, o2_q, o3_q;

        always_ff @(posedge clk) begin
            if (!rst || clr) begin
                o1_q <= '0;
                o2_q <= '0;
                o3_q <= '0;
            end else if (en) begin
                o1_q <= lane_sh1;
                o2_q <= lane_sh2;
                o3_q <= lane_sh3;
            end
        end

        assign sh1_out = o1_q;
        assign sh2_out = o2_q;
        assign sh3_out = o3_q;
    end else begin : g_out_comb
        assign sh1_out = lane_sh1;
        assign sh2_out = lane_sh2;
        assign sh3_out = lane_sh3;
    end

endmodule

// File: tb/tb_gf_inv_8_shared_pipe.sv
// Scoreboard bench: both OUT_REG variants share stimulus; expectations come from a brute-force field model.
module tb_gf_inv_8_shared_pipe;
    import gf_inv_8_shared_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, clr, in_valid;
    logic [31:0] sh1, sh2, sh3;
    logic [63:0] rnd;
    logic        ov0, ov1;
    logic [31:0] a1, a2, a3, b1, b2, b3;

    always #5 clk = ~clk;

    gf_inv_8_shared_pipe #(.LANES(4), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
        .sh1_in(sh1), .sh2_in(sh2), .sh3_in(sh3), .rnd(rnd),
        .out_valid(ov0), .sh1_out(a1), .sh2_out(a2), .sh3_out(a3));

    gf_inv_8_shared_pipe #(.LANES(4), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
        .sh1_in(sh1), .sh2_in(sh2), .sh3_in(sh3), .rnd(rnd),
        .out_valid(ov1), .sh1_out(b1), .sh2_out(b2), .sh3_out(b3));

    typedef struct {
        logic [31:0] x;
        int          cnt;
        int          tag;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  inv_tab[256];
    int          errors = 0;
    int          checks = 0;
    int          en_cnt = 0;
    int          kind   = 2;   // last edge: 0 advance, 1 frozen, 2 reset/clear
    logic [31:0] cur_x;
    int          cur_tag;
    logic        prev_v[2];
    logic [95:0] prev_o[2];
    logic [95:0] fresh[3];

    task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Field model: GF(4) via discrete logs of w, towers built from the normal-basis product rule.
    function automatic int lg2(logic [1:0] x);
        case (x)
            2'b11:   return 0;
            2'b01:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] m2(logic [1:0] x, logic [1:0] y);
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        case ((lg2(x) + lg2(y)) % 3)
            0:       return 2'b11;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [3:0] m4(logic [3:0] x, logic [3:0] y);
        logic [1:0] e;
        e = m2(m2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
        return {m2(x[3:2], y[3:2]) ^ e, m2(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic logic [7:0] m8(logic [7:0] x, logic [7:0] y);
        logic [3:0] e;
        e = m4(m4(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]), 4'b0001);
        return {m4(x[7:4], y[7:4]) ^ e, m4(x[3:0], y[3:0]) ^ e};
    endfunction

    function automatic logic [31:0] exp_word(logic [31:0] x);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = inv_tab[x[8*l +: 8]];
        return r;
    endfunction

    task automatic mon(input int id, input logic ov, input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3);
        logic [95:0] cur;
        exp_t        e;
        int          sz;
        int          lat;
        cur = {o1, o2, o3};
        lat = (id == 0) ? 2 : 3;
        if (kind == 2) begin
            chk("clear_valid", ov == 1'b0, 128'(ov), 128'(0));
            chk("clear_data", cur == 96'h0, 128'(cur), 128'(0));
        end else if (kind == 1) begin
            chk("stall_hold", {ov, cur} == {prev_v[id], prev_o[id]}, 128'({ov, cur}), 128'({prev_v[id], prev_o[id]}));
        end else if (ov) begin
            sz = (id == 0) ? q0.size() : q1.size();
            chk("valid_expected", sz != 0, 128'(ov), 128'(0));
            if (sz != 0) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk("data", (o1 ^ o2 ^ o3) == exp_word(e.x), 128'(o1 ^ o2 ^ o3), 128'(exp_word(e.x)));
                chk("latency", en_cnt == e.cnt + lat - 1, 128'(en_cnt - e.cnt + 1), 128'(lat));
                if (id == 0 && e.tag > 0) fresh[e.tag] = cur;
            end
        end
        prev_v[id] = ov;
        prev_o[id] = cur;
    endtask

    always @(negedge clk) begin
        mon(0, ov0, a1, a2, a3);
        mon(1, ov1, b1, b2, b3);
    end

    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (!rst || clr) begin
            q0.delete();
            q1.delete();
            kind = 2;
        end else if (!en) begin
            kind = 1;
        end else begin
            kind = 0;
            en_cnt++;
            if (in_valid) begin
                e.x = cur_x; e.cnt = en_cnt; e.tag = cur_tag;
                q0.push_back(e);
                q1.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic v, input logic e, input logic c, input logic r, input int tag);
        logic [31:0] s1, s2;
        s1 = $urandom; s2 = $urandom;
        sh1 = s1; sh2 = s2; sh3 = x ^ s1 ^ s2;
        in_valid = v; en = e; clr = c; rst = r;
        rnd = {$urandom, $urandom};
        cur_x = x; cur_tag = tag;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    initial begin
        logic [31:0] w;
        int          found;
        fresh[1] = '0; fresh[2] = '0;
        rst = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
        sh1 = '0; sh2 = '0; sh3 = '0; rnd = '0; cur_x = '0; cur_tag = 0;

        inv_tab[0] = 8'h00;
        for (int x = 1; x < 256; x++) begin
            found = 0;
            for (int y = 1; y < 256; y++)
                if (m8(8'(x), 8'(y)) == 8'hFF) begin inv_tab[x] = 8'(y); found++; end
            chk("model_unique_inverse", found == 1, 128'(found), 128'(1));
        end
        for (int x = 0; x < 256; x++)
            chk("pkg_inv", gf_inv_8(8'(x)) == inv_tab[x], 128'(gf_inv_8(8'(x))), 128'(inv_tab[x]));

        for (int i = 0; i < 3; i++) drive(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        drive($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        idle(5);

        for (int i = 0; i < 250; i++) drive(32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 64; i++) begin
            for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(4*i + l);
            drive(w, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        end
        idle(4);

        for (int i = 0; i < 400; i++)
            drive($urandom, ($urandom % 4) != 0, ($urandom % 4) != 0, 1'b0, 1'b1, 0);
        idle(5);

        w = $urandom;
        drive(w, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) drive(w, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        idle(5);

        drive($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        drive($urandom, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        idle(5);
        drive($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        drive($urandom, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(5);
        drive($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        drive($urandom, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        idle(5);

        drive(32'h53535353, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        drive(32'h53535353, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        idle(6);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
        chk("drain_q0", q0.size() == 0, 128'(q0.size()), 128'(0));
        chk("drain_q1", q1.size() == 0, 128'(q1.size()), 128'(0));
        chk("fresh_shares_differ", fresh[1] != fresh[2], 128'(fresh[1]), 128'(fresh[2]));
        chk("fresh_xor_equal",
            (fresh[1][95:64] ^ fresh[1][63:32] ^ fresh[1][31:0]) == (fresh[2][95:64] ^ fresh[2][63:32] ^ fresh[2][31:0]),
            128'(fresh[1][95:64] ^ fresh[1][63:32] ^ fresh[1][31:0]),
            128'(fresh[2][95:64] ^ fresh[2][63:32] ^ fresh[2][31:0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
